// File: rtl/picorv_hpdc_pkg.sv
// Shared types and constants for the picorv32 <-> HPDcache requester-0 adapter.
// Cache request/response types mirror the fields of hpdcache_typedef.svh used by the adapter.
package picorv_hpdc_pkg;

  localparam int unsigned TID_WIDTH        = 4;
  localparam int unsigned TAG_WIDTH        = 20;
  localparam int unsigned REQ_OFFSET_WIDTH = 12;

  localparam logic [31:0] PHYS_MEM_LIMIT_DEF = 32'h0002_0000;
  localparam logic [31:0] TIMEOUT_DATA       = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ACK  = 2'd3
  } adapter_state_e;

  typedef enum logic [3:0] {
    HPDCACHE_REQ_LOAD  = 4'h0,
    HPDCACHE_REQ_STORE = 4'h1
  } hpdcache_req_op_t;

  typedef enum logic [2:0] {
    HPDCACHE_WR_POLICY_AUTO = 3'b001,
    HPDCACHE_WR_POLICY_WB   = 3'b010,
    HPDCACHE_WR_POLICY_WT   = 3'b100
  } hpdcache_wr_policy_hint_t;

  typedef logic [TAG_WIDTH-1:0] hpdcache_tag_t;

  typedef struct packed {
    logic                     uncacheable;
    logic                     io;
    hpdcache_wr_policy_hint_t wr_policy_hint;
  } hpdcache_pma_t;

  typedef struct packed {
    logic [REQ_OFFSET_WIDTH-1:0] addr_offset;
    logic [31:0]                 wdata;
    hpdcache_req_op_t            op;
    logic [3:0]                  be;
    logic [2:0]                  size;
    logic [2:0]                  sid;
    logic [TID_WIDTH-1:0]        tid;
    logic                        need_rsp;
    logic                        phys_indexed;
    hpdcache_tag_t               addr_tag;
    hpdcache_pma_t               pma;
  } hpdcache_req_t;

  typedef struct packed {
    logic [31:0]          rdata;
    logic [TID_WIDTH-1:0] tid;
    logic                 error;
  } hpdcache_rsp_t;

  function automatic hpdcache_req_op_t op_from_wstrb(input logic [3:0] wstrb);
    if (|wstrb) begin
      return HPDCACHE_REQ_STORE;
    end else begin
      return HPDCACHE_REQ_LOAD;
    end
  endfunction

endpackage

// File: rtl/picorv_hpdc_adapter_if.sv
// Requester-0 port of hpdcache_wrapper: request handshake, physical tag and response.
interface picorv_hpdc_adapter_if;
  import picorv_hpdc_pkg::*;

  logic          core_req_valid;
  logic          core_req_ready;
  hpdcache_req_t core_req;
  logic          core_req_abort;
  hpdcache_tag_t core_req_tag;
  logic          core_rsp_valid;
  hpdcache_rsp_t core_rsp;

  modport master (
    output core_req_valid, core_req, core_req_abort, core_req_tag,
    input  core_req_ready, core_rsp_valid, core_rsp
  );

  modport slave (
    input  core_req_valid, core_req, core_req_abort, core_req_tag,
    output core_req_ready, core_rsp_valid, core_rsp
  );
endinterface

// File: rtl/picorv_hpdc_adapter.sv
// Bridges the picorv32 native memory port onto HPDcache requester 0 (IDLE->REQ->RESP->ACK).
// Optional RESP watchdog enabled by defining PICORV_HPDC_TIMEOUT_EN.
module picorv_hpdc_adapter
  import picorv_hpdc_pkg::*;
#(
  parameter logic [31:0] PhysMemLimit  = PHYS_MEM_LIMIT_DEF,
`ifdef PICORV_HPDC_TIMEOUT_EN
  parameter int unsigned TimeoutCycles = 1024,
`endif
  parameter int unsigned TidWidth      = TID_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         mem_valid_i,
  input  logic [31:0]                  mem_addr_i,
  input  logic [31:0]                  mem_wdata_i,
  input  logic [3:0]                   mem_wstrb_i,
  output logic                         mem_ready_o,
  output logic [31:0]                  mem_rdata_o,
  picorv_hpdc_adapter_if.master        hpdc,
  output logic                         err_o
);

  adapter_state_e      r_state;
  adapter_state_e      w_state_nxt;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [TidWidth-1:0] r_tid;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic                r_req_valid;
  logic                r_mem_ready;
  logic                w_rsp_hit;
  logic                w_timeout;
  hpdcache_req_t       w_req;

  assign w_rsp_hit = (r_state == RESP) && hpdc.core_rsp_valid &&
                     (TidWidth'(hpdc.core_rsp.tid) == r_tid);

`ifdef PICORV_HPDC_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles);
  logic [TmoW-1:0] r_tmo_cnt;

  // Watchdog: cleared while the request is outstanding, counts RESP cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (r_state == REQ) begin
      r_tmo_cnt <= '0;
    end else if (r_state == RESP) begin
      r_tmo_cnt <= r_tmo_cnt + {{(TmoW-1){1'b0}}, 1'b1};
    end
  end

  assign w_timeout = (r_state == RESP) && (r_tmo_cnt == TmoW'(TimeoutCycles - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (mem_valid_i) w_state_nxt = REQ;
        else             w_state_nxt = IDLE;
      end
      REQ: begin
        if (hpdc.core_req_ready) w_state_nxt = RESP;
        else                     w_state_nxt = REQ;
      end
      RESP: begin
        if (w_rsp_hit || w_timeout) w_state_nxt = ACK;
        else                        w_state_nxt = RESP;
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, latched CPU access, response data, sticky error and rolling tid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_wstrb     <= 4'b0000;
      r_tid       <= '0;
      r_rdata     <= 32'h0000_0000;
      r_err       <= 1'b0;
      r_req_valid <= 1'b0;
      r_mem_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_valid <= (w_state_nxt == REQ);
      r_mem_ready <= (w_state_nxt == ACK);
      if ((r_state == IDLE) && mem_valid_i) begin
        r_addr  <= mem_addr_i;
        r_wdata <= mem_wdata_i;
        r_wstrb <= mem_wstrb_i;
      end
      // A matching response wins over a watchdog expiry in the same cycle.
      if (w_rsp_hit) begin
        if (hpdc.core_rsp.error) begin
          r_rdata <= 32'h0000_0000;
          r_err   <= 1'b1;
        end else if (r_wstrb == 4'b0000) begin
          r_rdata <= hpdc.core_rsp.rdata;
        end
      end else if (w_timeout) begin
        r_rdata <= TIMEOUT_DATA;
        r_err   <= 1'b1;
      end
      if (r_state == ACK) begin
        r_tid <= r_tid + {{(TidWidth-1){1'b0}}, 1'b1};
      end
    end
  end

  // Request payload built purely from latched registers, so it cannot move mid-handshake.
  always_comb begin
    w_req                    = '0;
    w_req.addr_offset        = r_addr[REQ_OFFSET_WIDTH-1:0];
    w_req.wdata              = r_wdata;
    w_req.op                 = op_from_wstrb(r_wstrb);
    w_req.be                 = r_wstrb;
    w_req.size               = 3'd2;
    w_req.sid                = 3'd0;
    w_req.tid                = TID_WIDTH'(r_tid);
    w_req.need_rsp           = 1'b1;
    w_req.phys_indexed       = 1'b1;
    w_req.addr_tag           = r_addr[31 -: TAG_WIDTH];
    w_req.pma.uncacheable    = (r_addr >= PhysMemLimit);
    w_req.pma.io             = (r_addr >= PhysMemLimit);
    w_req.pma.wr_policy_hint = HPDCACHE_WR_POLICY_WB;
  end

  assign hpdc.core_req_valid = r_req_valid;
  assign hpdc.core_req       = r_req_valid ? w_req : '0;
  assign hpdc.core_req_tag   = r_req_valid ? r_addr[31 -: TAG_WIDTH] : '0;
  assign hpdc.core_req_abort = 1'b0;
  assign mem_ready_o         = r_mem_ready;
  assign mem_rdata_o         = r_rdata;
  assign err_o               = r_err;

endmodule

// File: tb/tb_picorv_hpdc_adapter.sv
// Self-checking bench for picorv_hpdc_adapter: plays CPU and cache, checks against a transaction-level model.
module tb_picorv_hpdc_adapter;
  import picorv_hpdc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  int          m_tid;
  bit          m_err;
  logic [31:0] m_rdata;

  picorv_hpdc_adapter_if ifc ();

`ifdef PICORV_HPDC_TIMEOUT_EN
  picorv_hpdc_adapter #(.TimeoutCycles(8)) dut (
`else
  picorv_hpdc_adapter dut (
`endif
    .clk_i(clk), .rst_ni(rst_ni), .mem_valid_i(mem_valid), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_wstrb_i(mem_wstrb), .mem_ready_o(mem_ready),
    .mem_rdata_o(mem_rdata), .hpdc(ifc), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic hpdcache_req_t expected_req(input logic [31:0] addr, input logic [31:0] wdata,
                                                 input logic [3:0] wstrb, input int tid);
    hpdcache_req_t r;
    r = '0;
    r.addr_offset        = addr[11:0];
    r.wdata              = wdata;
    r.op                 = (wstrb != 4'b0000) ? HPDCACHE_REQ_STORE : HPDCACHE_REQ_LOAD;
    r.be                 = wstrb;
    r.size               = 3'd2;
    r.tid                = tid[TID_WIDTH-1:0];
    r.need_rsp           = 1'b1;
    r.phys_indexed       = 1'b1;
    r.addr_tag           = addr[31:12];
    r.pma.uncacheable    = (addr >= 32'h0002_0000);
    r.pma.io             = (addr >= 32'h0002_0000);
    r.pma.wr_policy_hint = HPDCACHE_WR_POLICY_WB;
    return r;
  endfunction

  task automatic model_reset();
    m_tid   = 0;
    m_err   = 1'b0;
    m_rdata = 32'h0000_0000;
  endtask

  // One full CPU access; cache accepts after rdy_dly cycles, replies rsp_dly cycles later.
  task automatic do_access(input string nm, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int rdy_dly, input int rsp_dly,
                           input bit bad_first, input bit rsp_err, input logic [31:0] rsp_data);
    hpdcache_req_t exp;
    exp = expected_req(addr, wdata, wstrb, m_tid);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    @(negedge clk);
    for (int c = 0; c <= rdy_dly; c++) begin
      n_checks++;
      if (ifc.core_req_valid !== 1'b1 || ifc.core_req !== exp || ifc.core_req_tag !== addr[31:12]
          || ifc.core_req_abort !== 1'b0 || mem_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL %s req cyc%0d: valid=%b req=%h tag=%h rdy=%b, want valid=1 req=%h tag=%h rdy=0",
                 nm, c, ifc.core_req_valid, ifc.core_req, ifc.core_req_tag, mem_ready, exp, addr[31:12]);
      end
      if (c == rdy_dly) ifc.core_req_ready = 1'b1;
      @(negedge clk);
    end
    ifc.core_req_ready = 1'b0;
    n_checks++;
    if (ifc.core_req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s valid_drop: got %b want 0", nm, ifc.core_req_valid);
    end
    for (int d = 0; d < rsp_dly; d++) @(negedge clk);
    if (bad_first) begin
      ifc.core_rsp_valid = 1'b1;
      ifc.core_rsp.tid   = TID_WIDTH'(m_tid + 1);
      ifc.core_rsp.rdata = $urandom;
      ifc.core_rsp.error = 1'b0;
      @(negedge clk);
      ifc.core_rsp_valid = 1'b0;
      n_checks++;
      if (mem_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL %s stale_tid: mem_ready=%b want 0", nm, mem_ready);
      end
    end
    ifc.core_rsp_valid = 1'b1;
    ifc.core_rsp.tid   = TID_WIDTH'(m_tid);
    ifc.core_rsp.rdata = rsp_data;
    ifc.core_rsp.error = rsp_err;
    @(negedge clk);
    ifc.core_rsp_valid = 1'b0;
    if (rsp_err) begin
      m_rdata = 32'h0000_0000;
      m_err   = 1'b1;
    end else if (wstrb == 4'b0000) begin
      m_rdata = rsp_data;
    end
    m_tid = (m_tid + 1) % (1 << TID_WIDTH);
    n_checks++;
    if (mem_ready !== 1'b1 || mem_rdata !== m_rdata || err !== m_err) begin
      n_errors++;
      $display("FAIL %s complete: ready=%b rdata=%h err=%b want ready=1 rdata=%h err=%b",
               nm, mem_ready, mem_rdata, err, m_rdata, m_err);
    end
    mem_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL %s single_pulse: mem_ready=%b want 0", nm, mem_ready);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    ifc.core_req_ready = 1'b0; ifc.core_rsp_valid = 1'b0; ifc.core_rsp = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || err !== 1'b0 || ifc.core_req_valid !== 1'b0
        || ifc.core_req !== '0 || ifc.core_req_tag !== '0 || ifc.core_req_abort !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: ready=%b rdata=%h err=%b valid=%b req=%h, want all zero",
               mem_ready, mem_rdata, err, ifc.core_req_valid, ifc.core_req);
    end
  endtask

  task automatic test_directed();
    do_access("load_basic", 32'h0000_0100, 32'h0, 4'b0000, 0, 2, 1'b0, 1'b0, 32'h1234_5678);
    do_access("store_mmio_bp", 32'h0002_0004, 32'h0000_0041, 4'b0001, 5, 1, 1'b0, 1'b0, 32'h0BAD_0BAD);
    do_access("limit_below", 32'h0001_FFFC, 32'h0, 4'b0000, 1, 0, 1'b0, 1'b0, 32'hCAFE_F00D);
    do_access("limit_at", 32'h0002_0000, 32'h0, 4'b0000, 0, 0, 1'b0, 1'b0, 32'h0000_0077);
    do_access("tid_mismatch", 32'h0000_0200, 32'h0, 4'b0000, 0, 1, 1'b1, 1'b0, 32'h0000_00A5);
  endtask

  task automatic test_error();
    do_access("err_load", 32'h0000_0300, 32'h0, 4'b0000, 0, 1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    do_access("after_err_load", 32'h0000_0304, 32'h0, 4'b0000, 2, 0, 1'b0, 1'b0, 32'h1111_2222);
    do_access("after_err_store", 32'h0000_0308, 32'h5555_AAAA, 4'b1111, 0, 3, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic [3:0] ws;
    for (int i = 0; i < 40; i++) begin
      ws = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      do_access("random", $urandom & 32'h0003_FFFC, $urandom, ws, $urandom_range(0, 4),
                $urandom_range(0, 4), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 15) == 0), $urandom);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0000_0400; mem_wstrb = 4'b0000;
    @(negedge clk);
    ifc.core_req_ready = 1'b1;
    @(negedge clk);
    ifc.core_req_ready = 1'b0;
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || err !== 1'b0 || ifc.core_req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: ready=%b rdata=%h err=%b valid=%b want all 0",
               mem_ready, mem_rdata, err, ifc.core_req_valid);
    end
    mem_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    do_access("post_reset_load", 32'h0000_0500, 32'h0, 4'b0000, 0, 1, 1'b0, 1'b0, 32'h0F0F_1234);
  endtask

`ifdef PICORV_HPDC_TIMEOUT_EN
  task automatic test_timeout();
    int waited;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0000_0600; mem_wstrb = 4'b0000;
    @(negedge clk);
    ifc.core_req_ready = 1'b1;
    @(negedge clk);
    ifc.core_req_ready = 1'b0;
    waited = 0;
    while (mem_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (mem_ready !== 1'b1 || waited != 8 || mem_rdata !== 32'hDEAD_BEEF || err !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout: ready=%b waited=%0d rdata=%h err=%b want ready=1 waited=8 rdata=deadbeef err=1",
               mem_ready, waited, mem_rdata, err);
    end
    mem_valid = 1'b0;
    ifc.core_rsp_valid = 1'b1;
    ifc.core_rsp.tid   = TID_WIDTH'(m_tid);
    ifc.core_rsp.rdata = 32'h1357_9BDF;
    ifc.core_rsp.error = 1'b0;
    m_tid = (m_tid + 1) % (1 << TID_WIDTH);
    m_err = 1'b1;
    m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    ifc.core_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL late_rsp: ready=%b rdata=%h want ready=0 rdata=deadbeef", mem_ready, mem_rdata);
    end
    do_access("after_timeout", 32'h0000_0604, 32'h0, 4'b0000, 0, 1, 1'b0, 1'b0, 32'h2468_ACE0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_error();
    test_random();
    test_reset_mid();
`ifdef PICORV_HPDC_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
